// File: rtl/sram_port_arbiter.sv
// Arbiter that shares one SRAM between the instruction-fetch port and the data port.
// Each grant runs a fixed-length SRAM cycle; simultaneous requests alternate round-robin.
module sram_port_arbiter #(
   parameter int SRAM_LATENCY = 6,
   parameter int ADDR_OFFSET  = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ready,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic [16:0] SRAM_ADDR,
   inout  wire  [31:0] SRAM_DQ,
   output logic        SRAM_WE_N,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int          CW     = $clog2(SRAM_LATENCY);
   localparam logic [CW-1:0] LAST = CW'(SRAM_LATENCY - 1);
   localparam logic [31:0] OFFSET = 32'(ADDR_OFFSET);

   state_t          state_r;
   logic [CW-1:0]   cnt_r;
   logic            rr_ptr_r;
   logic            gnt_d_r;
   logic            wr_r;
   logic            dq_oe_r;
   logic [31:0]     dq_out_r;

   logic            i_pend_s;
   logic            d_pend_s;
   logic            gnt_d_s;
   logic [16:0]     word_s;

   assign i_pend_s = i_req;
   assign d_pend_s = d_rd | d_wr;

   // Grant selection: rr_ptr low favours D on a tie, high favours I.
   always_comb begin
      gnt_d_s = 1'b0;
      word_s  = 17'd0;
      if (d_pend_s && (!i_pend_s || !rr_ptr_r)) begin
         gnt_d_s = 1'b1;
         word_s  = 17'((d_addr - OFFSET) >> 2);
      end else begin
         gnt_d_s = 1'b0;
         word_s  = 17'((i_addr - OFFSET) >> 2);
      end
   end

   // Access sequencer with all SRAM-side outputs and read data registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         rr_ptr_r  <= 1'b0;
         gnt_d_r   <= 1'b0;
         wr_r      <= 1'b0;
         dq_oe_r   <= 1'b0;
         dq_out_r  <= 32'd0;
         i_rdata   <= 32'd0;
         d_rdata   <= 32'd0;
         SRAM_ADDR <= 17'd0;
         SRAM_WE_N <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (i_pend_s || d_pend_s) begin
                  state_r   <= ACCESS;
                  cnt_r     <= '0;
                  gnt_d_r   <= gnt_d_s;
                  wr_r      <= gnt_d_s & d_wr;
                  dq_oe_r   <= gnt_d_s & d_wr;
                  dq_out_r  <= d_wdata;
                  SRAM_ADDR <= word_s;
                  SRAM_WE_N <= ~(gnt_d_s & d_wr);
                  rr_ptr_r  <= gnt_d_s;
                  busy      <= 1'b1;
               end else begin
                  state_r   <= IDLE;
               end
            end
            ACCESS: begin
               if (cnt_r == LAST) begin
                  state_r   <= DONE;
                  SRAM_WE_N <= 1'b1;
                  dq_oe_r   <= 1'b0;
                  // Read data is captured at the end of the access even if the request was dropped.
                  if (!wr_r) begin
                     if (gnt_d_r) begin
                        d_rdata <= SRAM_DQ;
                     end else begin
                        i_rdata <= SRAM_DQ;
                     end
                  end else begin
                     d_rdata <= d_rdata;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            DONE: begin
               state_r <= IDLE;
               cnt_r   <= '0;
               busy    <= 1'b0;
            end
            default: begin
               state_r   <= IDLE;
               cnt_r     <= '0;
               dq_oe_r   <= 1'b0;
               SRAM_WE_N <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign SRAM_DQ = dq_oe_r ? dq_out_r : {32{1'bz}};

   // Freeze semantics: ready is low while a request waits, except for its completion pulse.
   assign i_ready = ~i_req | ((state_r == DONE) & ~gnt_d_r);
   assign d_ready = ~(d_rd | d_wr) | ((state_r == DONE) & gnt_d_r);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: drivers queue expected completions, a monitor checks them on each ready pulse.
// A second instance with SRAM_LATENCY=2 covers the short-latency and top-address case.
module tb_sram_port_arbiter;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic        i_req, d_rd, d_wr;
   logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
   logic        i_ready, d_ready, sram_we_n, busy;
   logic [16:0] sram_addr;
   wire  [31:0] sram_dq;

   logic        d2_rd;
   logic [31:0] d2_addr, i2_rdata, d2_rdata;
   logic        i2_ready, d2_ready, sram_we_n2, busy2;
   logic [16:0] sram_addr2;
   wire  [31:0] sram_dq2;

   logic [31:0] mem [0:255];
   exp_t        iq[$];
   exp_t        dq_exp[$];
   exp_t        d2q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_port_arbiter #(.SRAM_LATENCY(6), .ADDR_OFFSET(1024)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(sram_we_n), .busy(busy)
   );

   sram_port_arbiter #(.SRAM_LATENCY(2), .ADDR_OFFSET(1024)) dut2 (
      .clk(clk), .reset(reset),
      .i_req(1'b0), .i_addr(32'd0), .i_rdata(i2_rdata), .i_ready(i2_ready),
      .d_rd(d2_rd), .d_wr(1'b0), .d_addr(d2_addr), .d_wdata(32'd0),
      .d_rdata(d2_rdata), .d_ready(d2_ready),
      .SRAM_ADDR(sram_addr2), .SRAM_DQ(sram_dq2), .SRAM_WE_N(sram_we_n2), .busy(busy2)
   );

   // SRAM models: the main one stores writes, the short one returns its own word address.
   assign sram_dq  = (busy && sram_we_n) ? mem[sram_addr[7:0]] : {32{1'bz}};
   assign sram_dq2 = (busy2 && sram_we_n2) ? {15'd0, sram_addr2} : {32{1'bz}};
   always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=missing expected=event (cycle %0d)", name, cyc);
   endtask

   // Monitor: every completion pulse pops one expectation for that port.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && i_req && i_ready) begin
            if (iq.size() == 0) flag("i_unexpected_completion");
            else begin
               e = iq.pop_front();
               check32("i_rdata", i_rdata, e.data);
               check32("i_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
         if (!reset && (d_rd || d_wr) && d_ready) begin
            if (dq_exp.size() == 0) flag("d_unexpected_completion");
            else begin
               e = dq_exp.pop_front();
               check32("d_rdata", d_rdata, e.data);
               check32("d_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
         if (!reset && d2_rd && d2_ready) begin
            if (d2q.size() == 0) flag("d2_unexpected_completion");
            else begin
               e = d2q.pop_front();
               check32("d2_rdata", d2_rdata, e.data);
               check32("d2_cycle", 32'(cyc), 32'(e.cyc));
               check32("d2_sram_addr", {15'd0, sram_addr2}, 32'h0001_FFFF);
            end
         end
      end
   end

   task automatic i_access(input logic [31:0] addr, input logic [31:0] exp_data, input int lat);
      exp_t e;
      int   n = 0;
      i_req  = 1'b1;
      i_addr = addr;
      e.data = exp_data;
      e.cyc  = cyc + lat;
      iq.push_back(e);
      do begin
         @(negedge clk);
         n++;
      end while (!i_ready && n < 40);
      if (!i_ready) flag("i_timeout");
      @(posedge clk);
      #1;
      i_req = 1'b0;
   endtask

   task automatic d_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input int lat,
                           input logic [16:0] exp_word, input int exp_we);
      exp_t e;
      int   n = 0;
      int   we_cnt = 0;
      d_rd    = ~wr;
      d_wr    = wr;
      d_addr  = addr;
      d_wdata = wdata;
      e.data  = exp_rdata;
      e.cyc   = cyc + lat;
      dq_exp.push_back(e);
      do begin
         @(negedge clk);
         n++;
         if (!sram_we_n) begin
            we_cnt++;
            check32("d_write_addr", {15'd0, sram_addr}, {15'd0, exp_word});
         end
      end while (!d_ready && n < 40);
      if (!d_ready) flag("d_timeout");
      check32("d_we_cycles", 32'(we_cnt), 32'(exp_we));
      @(posedge clk);
      #1;
      d_rd = 1'b0;
      d_wr = 1'b0;
   endtask

   initial begin
      exp_t e;
      int   n;
      for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + 32'(k);
      reset = 1'b1;
      i_req = 1'b0; i_addr = 32'd0;
      d_rd = 1'b0; d_wr = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
      d2_rd = 1'b0; d2_addr = 32'd0;
      repeat (2) @(negedge clk);
      check32("rst_i_rdata", i_rdata, 32'd0);
      check32("rst_d_rdata", d_rdata, 32'd0);
      check32("rst_sram_addr", {15'd0, sram_addr}, 32'd0);
      check32("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      check32("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;

      // Idle for 20 cycles.
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check32("idle_ready", {30'd0, i_ready, d_ready}, 32'd3);
         check32("idle_busy_we", {30'd0, busy, sram_we_n}, 32'd1);
      end

      // First tie after reset: D first, I waits a full extra slot.
      fork
         i_access(32'd1036, 32'h1000_0003, 15);
         d_access(1'b0, 32'd1032, 32'd0, 32'h1000_0002, 7, 17'd2, 0);
      join

      // D write then read-back at word 1 (D granted last, so the next tie goes to I).
      @(negedge clk);
      d_access(1'b1, 32'd1028, 32'hDEAD_BEEF, 32'h1000_0002, 7, 17'd1, 6);
      d_access(1'b0, 32'd1028, 32'd0, 32'hDEAD_BEEF, 7, 17'd1, 0);

      @(negedge clk);
      fork
         i_access(32'd1044, 32'h1000_0005, 7);
         d_access(1'b0, 32'd1028, 32'd0, 32'hDEAD_BEEF, 15, 17'd1, 0);
      join

      // Back-to-back I reads with request held high.
      @(negedge clk);
      i_access(32'd1024, 32'h1000_0000, 7);
      fork
         i_access(32'd1028, 32'hDEAD_BEEF, 7);
         begin
            repeat (7) @(negedge clk);
            check32("i_rdata_hold", i_rdata, 32'h1000_0000);
         end
      join

      // Reset in the third access cycle of a write; the held request restarts it.
      @(negedge clk);
      d_rd = 1'b0; d_wr = 1'b1; d_addr = 32'd1040; d_wdata = 32'h1234_5678;
      repeat (3) @(negedge clk);
      check32("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
      reset = 1'b1;
      #1;
      check32("rst_mid_we_n", {31'd0, sram_we_n}, 32'd1);
      check32("rst_mid_busy", {31'd0, busy}, 32'd0);
      check32("rst_mid_d_ready", {31'd0, d_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      d_access(1'b1, 32'd1040, 32'h1234_5678, 32'd0, 7, 17'd4, 6);
      d_access(1'b0, 32'd1040, 32'd0, 32'h1234_5678, 7, 17'd4, 0);

      // Short-latency instance at the highest SRAM word.
      @(negedge clk);
      d2_rd   = 1'b1;
      d2_addr = 32'h0000_0400 + 32'h0007_FFFC;
      e.data  = 32'h0001_FFFF;
      e.cyc   = cyc + 3;
      d2q.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!d2_ready && n < 40);
      if (!d2_ready) flag("d2_timeout");
      @(posedge clk);
      #1;
      d2_rd = 1'b0;

      repeat (3) @(negedge clk);
      check32("iq_drained", 32'(iq.size()), 32'd0);
      check32("dq_drained", 32'(dq_exp.size()), 32'd0);
      check32("d2q_drained", 32'(d2q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
